// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, captures one debounced key per press,
// and hands the hex code to the consumer over a valid/ready interface with sticky overrun.
module keypad_scanner #(
  parameter int unsigned DWELL_CYCLES = 8192,
  parameter int unsigned REL_CYCLES   = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_db,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam int unsigned MAXC = (DWELL_CYCLES > REL_CYCLES) ? DWELL_CYCLES : REL_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST   = CW'(REL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_CAPTURE,
    ST_WAIT_REL
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   rel_q, rel_d;
  logic [3:0]      rows_q, rows_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            overrun_q, overrun_d;

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    rel_d       = rel_q;
    rows_d      = rows_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;

    if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_db == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            // Row pattern is latched so CAPTURE is immune to rows moving after the sample.
            rows_d  = row_db;
            state_d = ST_CAPTURE;
          end
        end else begin
          dwell_d = dwell_q + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (!key_valid_q || key_ready) begin
          key_code_d  = key_map(low_row(rows_q), col_idx_q);
          key_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        rel_d   = '0;
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (row_db != 4'hF) begin
          rel_d = '0;
        end else if (rel_q == REL_LAST) begin
          rel_d     = '0;
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else begin
          rel_d = rel_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      rel_q       <= '0;
      rows_q      <= 4'hF;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      rel_q       <= rel_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model that closes rows onto the driven column.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_db;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;
  logic       overrun_clr;

  // press[c] has a 1 for each row shorted to column c
  logic [3:0][3:0] press;

  int total;
  int bad;

  keypad_scanner #(
    .DWELL_CYCLES(16),
    .REL_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_db     (row_db),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_db = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (col[c] == 1'b0) row_db = row_db & ~press[c];
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    press       = '0;
    key_ready   = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col); end
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    total++;
    if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h exp=0", key_code); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    int idx;
    for (int k = 0; k <= 64; k++) begin
      idx     = (k / 16) % 4;
      exp_col = 4'b1111 ^ (4'b0001 << idx);
      total++;
      if (col !== exp_col) begin bad++; $display("FAIL idle_col k=%0d got=%b exp=%b", k, col, exp_col); end
      total++;
      if (key_valid !== 1'b0 || overrun !== 1'b0) begin
        bad++; $display("FAIL idle_flags k=%0d got=%b%b exp=00", k, key_valid, overrun);
      end
      if (k < 64) @(negedge clk);
    end
  endtask

  task automatic test_press_hold();
    bit ok;
    press[1] = 4'b0010;
    wait_valid(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL press5_timeout got=0 exp=1"); end
    total++;
    if (key_code !== 4'h5) begin bad++; $display("FAIL press5_code got=%h exp=5", key_code); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (col !== 4'b1101 || key_valid !== 1'b1 || key_code !== 4'h5) begin
        bad++; $display("FAIL press5_hold i=%0d got=%b/%b/%h exp=1101/1/5", i, col, key_valid, key_code);
      end
    end
  endtask

  task automatic test_release_handshake();
    press = '0;
    repeat (7) @(negedge clk);
    total++;
    if (col !== 4'b1101) begin bad++; $display("FAIL release_early got=%b exp=1101", col); end
    @(negedge clk);
    total++;
    if (col !== 4'b1011) begin bad++; $display("FAIL release_col got=%b exp=1011", col); end
    total++;
    if (key_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", key_valid); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL ready_clear got=%b exp=0", key_valid); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL ready_idle got=%b%b exp=00", key_valid, overrun);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    press[0] = 4'b0001;
    wait_valid(40, ok);
    total++;
    if (!ok || key_code !== 4'h1) begin bad++; $display("FAIL ovr_first got=%b/%h exp=1/1", ok, key_code); end
    press[0] = 4'b0000;
    press[2] = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL ovr_timeout got=0 exp=1"); end
    total++;
    if (key_code !== 4'h1 || key_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_retain got=%h/%b exp=1/1", key_code, key_valid);
    end
    press[2] = 4'b0000;
    repeat (12) @(negedge clk);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    press[2] = 4'b1000;
    wait_valid(200, ok);
    total++;
    if (!ok || key_code !== 4'hF) begin bad++; $display("FAIL hash_code got=%b/%h exp=1/f", ok, key_code); end
    press = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_multi_row_glitch();
    bit ok;
    do_reset();
    press[0] = 4'b0101;
    wait_valid(40, ok);
    total++;
    if (!ok || key_code !== 4'h1) begin bad++; $display("FAIL multi_code got=%b/%h exp=1/1", ok, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    total++;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_ack got=%b exp=0", key_valid); end
    press[0] = 4'b0000;
    repeat (5) @(negedge clk);
    press[0] = 4'b0101;
    @(negedge clk);
    press[0] = 4'b0000;
    repeat (7) @(negedge clk);
    total++;
    if (col !== 4'b1110 || key_valid !== 1'b0) begin
      bad++; $display("FAIL glitch_restart got=%b/%b exp=1110/0", col, key_valid);
    end
    @(negedge clk);
    total++;
    if (col !== 4'b1101 || key_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL glitch_done got=%b/%b/%b exp=1101/0/0", col, key_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    press[0] = 4'b0010;
    wait_valid(40, ok);
    total++;
    if (!ok || key_code !== 4'h4) begin bad++; $display("FAIL mid_code got=%b/%h exp=1/4", ok, key_code); end
    press[0] = 4'b0000;
    press[1] = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || col !== 4'b1101) begin bad++; $display("FAIL mid_setup got=%b/%b exp=1/1101", ok, col); end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (col !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || overrun !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%h/%b exp=1110/0/0/0", col, key_valid, key_code, overrun);
    end
    press = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (col !== 4'b1110 || key_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after got=%b/%b exp=1110/0", col, key_valid);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    press       = '0;
    key_ready   = 1'b0;
    overrun_clr = 1'b0;
    test_reset();
    test_idle_scan();
    test_press_hold();
    test_release_handshake();
    test_overrun();
    test_multi_row_glitch();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
